// File: rtl/rca36_nibble_seq.sv
// Digit-serial adder: one 4-bit ripple adder is reused for WIDTH/4 cycles,
// least significant nibble first, with valid/ready handshakes on both sides.

module rca_4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [4:0] c;

    always_comb begin
        c[0] = ci_i;
        s_o  = '0;
        for (int i = 0; i < 4; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        co_o = c[4];
    end

endmodule

module rca36_nibble_seq #(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int unsigned Steps = WIDTH / 4;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;

    logic [3:0]        nib_s;
    logic              nib_co;

    rca_4b u_rca (
        .a_i  (a_q[3:0]),
        .b_i  (b_q[3:0]),
        .ci_i (carry_q),
        .s_o  (nib_s),
        .co_o (nib_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        unique case (state_q)
            StIdle: begin
                // abort wins over a same-cycle operand handshake
                if (abort_i) begin
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end else if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    a_d     = a_q >> 4;
                    b_d     = b_q >> 4;
                    // sum nibble enters at the top; after Steps shifts it lands in place
                    s_d     = WIDTH'({nib_s, s_q} >> 4);
                    carry_d = nib_co;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Steps - 1)) begin
                        cout_d  = nib_co;
                        cnt_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = StIdle;
                end else if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign s_o         = s_q;
    assign cout_o      = cout_q;
    assign ovf_o       = (a_msb_q == b_msb_q) && (s_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_rca36_nibble_seq.sv
// Scoreboard bench for rca36_nibble_seq: expected results are queued at operand
// acceptance and compared when out_valid rises.

module tb_rca36_nibble_seq;

    typedef struct packed {
        logic [35:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] a_in = '0;
    logic [35:0] b_in = '0;
    logic        cin = 1'b0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rca36_nibble_seq #(.WIDTH(36)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .cin_i       (cin),
        .abort_i     (abort),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .s_o         (s),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic send_op(input logic [35:0] a, input logic [35:0] b, input logic c);
        exp_t        e;
        logic [36:0] sum;
        a_in     = a;
        b_in     = b;
        cin      = c;
        in_valid = 1'b1;
        sum      = {1'b0, a} + {1'b0, b} + 37'(c);
        e.s      = sum[35:0];
        e.cout   = sum[36];
        e.ovf    = (a[35] == b[35]) && (sum[35] != a[35]);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({s, cout, ovf, out_valid, busy, in_ready} !== {36'h0, 5'b00001}) begin
            n_err++;
            $display("FAIL reset_state: got s=%h cout=%b ovf=%b ov=%b busy=%b ir=%b, want 0/0/0/0/0/1",
                     s, cout, ovf, out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [35:0] av[7];
        logic [35:0] bv[7];
        logic        cv[7];
        exp_t        e;
        int          cyc;
        av[0] = 36'h000000001; bv[0] = 36'h000000001; cv[0] = 1'b0;
        av[1] = 36'hFFFFFFFFF; bv[1] = 36'h000000001; cv[1] = 1'b0;
        av[2] = 36'h7FFFFFFFF; bv[2] = 36'h000000000; cv[2] = 1'b1;
        av[3] = 36'h800000000; bv[3] = 36'h800000000; cv[3] = 1'b0;
        for (int i = 4; i < 7; i++) begin
            av[i] = 36'({$urandom(), $urandom()});
            bv[i] = 36'({$urandom(), $urandom()});
            cv[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 7; i++) begin
            send_op(av[i], bv[i], cv[i]);
            wait_done(cyc);
            n_vec++;
            if (cyc != 9) begin
                n_err++;
                $display("FAIL vec%0d_latency: got %0d cycles, want 9", i, cyc);
            end
            e = sb.pop_front();
            n_vec++;
            if ({s, cout, ovf} !== e) begin
                n_err++;
                $display("FAIL vec%0d_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                         i, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   cyc;
        send_op(36'h0ABCDEF01, 36'h123456789, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        in_valid = 1'b1;
        a_in     = 36'hFFFFFFFFF;
        b_in     = 36'hFFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({s, cout, ovf, out_valid, in_ready} !== {e, 2'b10}) begin
                n_err++;
                $display("FAIL hold%0d: got s=%h cout=%b ovf=%b ov=%b ir=%b, want s=%h cout=%b ovf=%b ov=1 ir=0",
                         i, s, cout, ovf, out_valid, in_ready, e.s, e.cout, e.ovf);
            end
        end
        in_valid = 1'b0;
        release_result();
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL hold_release: got ir=%b ov=%b busy=%b, want 1/0/0", in_ready, out_valid, busy);
        end
        n_vec++;
        if ({s, cout} !== {e.s, e.cout}) begin
            n_err++;
            $display("FAIL hold_keep: got s=%h cout=%b, want s=%h cout=%b", s, cout, e.s, e.cout);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        send_op(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({s, cout, ovf, out_valid, busy, in_ready} !== {36'h0, 5'b00001}) begin
            n_err++;
            $display("FAIL reset_mid: got s=%h cout=%b ovf=%b ov=%b busy=%b ir=%b, want 0/0/0/0/0/1",
                     s, cout, ovf, out_valid, busy, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_op(36'h123456789, 36'h111111111, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        n_vec++;
        if (cyc != 9 || {s, cout, ovf} !== e || s !== 36'h23456789A) begin
            n_err++;
            $display("FAIL after_reset: got s=%h cout=%b ovf=%b cyc=%0d, want s=23456789a cout=%b ovf=%b cyc=9",
                     s, cout, ovf, cyc, e.cout, e.ovf);
        end
        release_result();
    endtask

    task automatic test_abort();
        int seen;
        // abort beats in_valid in IDLE
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if ({in_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_idle: got ir=%b busy=%b, want 1/0", in_ready, busy);
        end
        send_op(36'h00000FFFF, 36'h000000001, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_run: got ir=%b ov=%b busy=%b, want 1/0/0", in_ready, out_valid, busy);
        end
        sb.delete();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_valid: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          cyc;
        logic [35:0] a;
        logic [35:0] b;
        for (int i = 0; i < 3; i++) begin
            a = 36'({$urandom(), $urandom()});
            b = 36'({$urandom(), $urandom()});
            send_op(a, b, 1'(i & 1));
            wait_done(cyc);
            n_vec++;
            if (cyc != 9) begin
                n_err++;
                $display("FAIL b2b%0d_latency: got %0d cycles, want 9", i, cyc);
            end
            e = sb.pop_front();
            n_vec++;
            if ({s, cout, ovf} !== e) begin
                n_err++;
                $display("FAIL b2b%0d_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                         i, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
